// File: rtl/cmn_entry_pool_dual_if.sv
// Allocation/release bus of the dual-port entry pool. The pool itself connects to the slave
// modport, and a requester or completion agent connects to the master modport.
interface cmn_entry_pool_dual_if #(
  parameter int unsigned ENTRY_NUM = 8
) ();
  localparam int unsigned IW = $clog2(ENTRY_NUM);
  localparam int unsigned CW = $clog2(ENTRY_NUM + 1);

  logic                 alloc_req_1;
  logic                 alloc_req_2;
  logic                 alloc_gnt_1;
  logic                 alloc_gnt_2;
  logic [ENTRY_NUM-1:0] alloc_idx_oh_1;
  logic [IW-1:0]        alloc_idx_bin_1;
  logic [ENTRY_NUM-1:0] alloc_idx_oh_2;
  logic [IW-1:0]        alloc_idx_bin_2;
  logic                 rel_vld_1;
  logic [IW-1:0]        rel_idx_1;
  logic                 rel_vld_2;
  logic [IW-1:0]        rel_idx_2;
  logic [ENTRY_NUM-1:0] busy_vec;
  logic [CW-1:0]        free_cnt;
  logic                 pool_full;
  logic                 pool_empty;
  logic                 rel_err;

  modport slave (
    input  alloc_req_1, alloc_req_2, rel_vld_1, rel_idx_1, rel_vld_2, rel_idx_2,
    output alloc_gnt_1, alloc_gnt_2, alloc_idx_oh_1, alloc_idx_bin_1,
           alloc_idx_oh_2, alloc_idx_bin_2, busy_vec, free_cnt, pool_full,
           pool_empty, rel_err
  );

  modport master (
    output alloc_req_1, alloc_req_2, rel_vld_1, rel_idx_1, rel_vld_2, rel_idx_2,
    input  alloc_gnt_1, alloc_gnt_2, alloc_idx_oh_1, alloc_idx_bin_1,
           alloc_idx_oh_2, alloc_idx_bin_2, busy_vec, free_cnt, pool_full,
           pool_empty, rel_err
  );
endinterface

// File: rtl/cmn_entry_pool_dual.sv
// Busy-bitmap tracker for an ENTRY_NUM-entry buffer. Each cycle it grants up to two of the
// lowest free entries and retires up to two entries, and it keeps a registered free count.
module cmn_entry_pool_dual #(
  parameter int unsigned ENTRY_NUM = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cmn_entry_pool_dual_if.slave  bus
);
  localparam int unsigned IW   = $clog2(ENTRY_NUM);
  localparam int unsigned CW   = $clog2(ENTRY_NUM + 1);
  localparam int unsigned PadW = 1 << IW;
  localparam logic [ENTRY_NUM-1:0] OneE = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

  logic [ENTRY_NUM-1:0] r_busy;
  logic [CW-1:0]        r_free;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_rel_err;

  logic                 w_f1_vld, w_f2_vld;
  logic [IW-1:0]        w_f1_idx, w_f2_idx;
  logic                 w_gnt_1, w_gnt_2;
  logic [IW-1:0]        w_idx_1, w_idx_2;
  logic [ENTRY_NUM-1:0] w_alloc_mask;
  logic [PadW-1:0]      w_busy_pad;
  logic                 w_rel_legal_1, w_rel_legal_2, w_rel_err;
  logic [ENTRY_NUM-1:0] w_rel_mask;
  logic [CW-1:0]        w_rel_cnt, w_gnt_cnt, w_free_next;
  logic [ENTRY_NUM-1:0] w_busy_next;

  // Two lowest free entries, taken from the registered bitmap only (no release bypass).
  always_comb begin
    w_f1_vld = 1'b0;
    w_f1_idx = '0;
    w_f2_vld = 1'b0;
    w_f2_idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!r_busy[i]) begin
        if (!w_f1_vld) begin
          w_f1_vld = 1'b1;
          w_f1_idx = IW'(i);
        end else if (!w_f2_vld) begin
          w_f2_vld = 1'b1;
          w_f2_idx = IW'(i);
        end
      end
    end
  end

  // A lone port-2 request takes F1. If port 1 is denied, F2 cannot exist either.
  always_comb begin
    w_gnt_1 = bus.alloc_req_1 & w_f1_vld;
    w_idx_1 = w_f1_idx;
    if (bus.alloc_req_1) begin
      w_gnt_2 = bus.alloc_req_2 & w_f2_vld;
      w_idx_2 = w_f2_idx;
    end else begin
      w_gnt_2 = bus.alloc_req_2 & w_f1_vld;
      w_idx_2 = w_f1_idx;
    end
  end

  assign w_alloc_mask = (w_gnt_1 ? (OneE << w_idx_1) : '0) |
                        (w_gnt_2 ? (OneE << w_idx_2) : '0);

  assign bus.alloc_gnt_1     = w_gnt_1;
  assign bus.alloc_gnt_2     = w_gnt_2;
  assign bus.alloc_idx_bin_1 = w_gnt_1 ? w_idx_1 : '0;
  assign bus.alloc_idx_bin_2 = w_gnt_2 ? w_idx_2 : '0;
  assign bus.alloc_idx_oh_1  = w_gnt_1 ? (OneE << w_idx_1) : '0;
  assign bus.alloc_idx_oh_2  = w_gnt_2 ? (OneE << w_idx_2) : '0;

  // Zero-padded so that out-of-range indices read as free rather than out of bounds.
  assign w_busy_pad = PadW'(r_busy);

  always_comb begin
    w_rel_legal_1 = bus.rel_vld_1 && (32'(bus.rel_idx_1) < ENTRY_NUM) &&
                    w_busy_pad[bus.rel_idx_1];
    w_rel_legal_2 = bus.rel_vld_2 && (32'(bus.rel_idx_2) < ENTRY_NUM) &&
                    w_busy_pad[bus.rel_idx_2] &&
                    !(bus.rel_vld_1 && (bus.rel_idx_1 == bus.rel_idx_2));
    w_rel_err     = (bus.rel_vld_1 && !w_rel_legal_1) || (bus.rel_vld_2 && !w_rel_legal_2);
    w_rel_mask    = (w_rel_legal_1 ? (OneE << bus.rel_idx_1) : '0) |
                    (w_rel_legal_2 ? (OneE << bus.rel_idx_2) : '0);
  end

  // Releases only hit busy entries, so the intermediate sum stays within ENTRY_NUM.
  always_comb begin
    w_rel_cnt   = CW'(w_rel_legal_1) + CW'(w_rel_legal_2);
    w_gnt_cnt   = CW'(w_gnt_1) + CW'(w_gnt_2);
    w_free_next = r_free + w_rel_cnt - w_gnt_cnt;
    w_busy_next = (r_busy & ~w_rel_mask) | w_alloc_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_free    <= CW'(ENTRY_NUM);
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_rel_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_next;
      r_free    <= w_free_next;
      r_full    <= (w_free_next == '0);
      r_empty   <= (w_free_next == CW'(ENTRY_NUM));
      r_rel_err <= w_rel_err;
    end
  end

  assign bus.busy_vec   = r_busy;
  assign bus.free_cnt   = r_free;
  assign bus.pool_full  = r_full;
  assign bus.pool_empty = r_empty;
  assign bus.rel_err    = r_rel_err;
endmodule
